line_mem_responder: RTL and testbench



---
 rtl/line_mem_responder_pkg.sv | 22 ++
 rtl/line_mem_responder_if.sv | 34 +++
 rtl/line_mem_responder_store.sv | 25 ++
 rtl/line_mem_responder.sv | 112 +++++++++++
 tb/tb_line_mem_responder.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/line_mem_responder_pkg.sv
// Shared types for the 256-bit line memory responder.
// Line geometry, FSM states and operation codes.
package mem_line_pkg;

  localparam int LINE_W   = 256;
  localparam int ADDR_W   = 16;
  localparam int OFFSET_W = 5;

  typedef logic [LINE_W-1:0] line_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } mem_op_e;

endpackage

// File: rtl/line_mem_responder_if.sv
// Line read/write bus between an initiator (L1 cache)
// and the memory-side responder.
interface line_mem_responder_if
  import mem_line_pkg::*;
#(
  parameter int LW = 256
);

  logic              read;
  logic              write;
  logic [ADDR_W-1:0] address;
  logic [LW-1:0]     wdata;
  logic              resp;
  logic [LW-1:0]     rdata;

  modport master (
    output read,
    output write,
    output address,
    output wdata,
    input  resp,
    input  rdata
  );

  modport slave (
    input  read,
    input  write,
    input  address,
    input  wdata,
    output resp,
    output rdata
  );

endinterface

// File: rtl/line_mem_responder_store.sv
// Single-port line array; kept standalone so a vendor
// RAM macro can replace it without touching the FSM.
module line_store #(
  parameter int NUM_LINES = 2048,
  parameter int LINE_W    = 256,
  parameter int IDX_W     = $clog2(NUM_LINES)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [LINE_W-1:0] wdata,
  output logic [LINE_W-1:0] rdata
);

  logic [LINE_W-1:0] mem [NUM_LINES];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/line_mem_responder.sv
// Fixed-latency line memory responder: latches a request,
// waits LATENCY cycles, then pulses resp for one cycle.
module line_mem_responder
  import mem_line_pkg::*;
#(
  parameter int LATENCY   = 4,
  parameter int NUM_LINES = 2048,
  parameter int LINE_W    = mem_line_pkg::LINE_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  line_mem_responder_if.slave  bus,
  output logic                 err
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  mem_state_e        state;
  mem_op_e           op_q;
  logic [3:0]        cnt;
  logic              rd_q;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [IDX_W-1:0]  idx_q;
  logic [LINE_W-1:0] wdata_q;
  logic [LINE_W-1:0] store_rdata;
  logic              req;
  logic              viol;
  logic              we;
  logic              in_resp;

  always_comb begin
    req     = bus.read | bus.write;
    viol    = (bus.read != rd_q)
            | (bus.write != wr_q)
            | (bus.address != addr_q);
    in_resp = (state == RESP);
    // A reset on the RESP edge must not commit the write
    we      = in_resp && (op_q == OP_WR) && rst_n;
  end

  always_comb begin
    bus.resp  = in_resp;
    bus.rdata = '0;
    if (in_resp && (op_q == OP_RD)) begin
      bus.rdata = store_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      op_q    <= OP_RD;
      cnt     <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      err     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req) begin
            rd_q    <= bus.read;
            wr_q    <= bus.write;
            addr_q  <= bus.address;
            idx_q   <= bus.address[OFFSET_W +: IDX_W];
            wdata_q <= bus.wdata;
            op_q    <= bus.write ? OP_WR : OP_RD;
            cnt     <= CNT_LOAD;
            state   <= (LATENCY == 1) ? RESP : WAIT;
            if (bus.read & bus.write) begin
              err <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (viol) begin
            err <= 1'b1;
          end
          if (cnt <= 4'd1) begin
            cnt   <= '0;
            state <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  line_store #(
    .NUM_LINES (NUM_LINES),
    .LINE_W    (LINE_W),
    .IDX_W     (IDX_W)
  ) u_store (
    .clk   (clk),
    .we    (we),
    .idx   (idx_q),
    .wdata (wdata_q),
    .rdata (store_rdata)
  );

endmodule

// File: tb/tb_line_mem_responder.sv
// Directed bench: a LATENCY=4 / 2048-line responder and a
// LATENCY=1 / 256-line responder on a shared stimulus bus.
module tb_line_mem_responder;
  import mem_line_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         sel;
  logic         rd;
  logic         wr;
  logic [15:0]  addr;
  logic [255:0] wd;
  logic         resp;
  logic [255:0] rdata;
  logic         err1;
  logic         err2;
  int           vecs = 0;
  int           errs = 0;

  always #5 clk = ~clk;

  line_mem_responder_if bus1 ();
  line_mem_responder_if bus2 ();

  assign bus1.read    = !sel & rd;
  assign bus1.write   = !sel & wr;
  assign bus1.address = sel ? 16'h0 : addr;
  assign bus1.wdata   = sel ? '0 : wd;
  assign bus2.read    = sel & rd;
  assign bus2.write   = sel & wr;
  assign bus2.address = sel ? addr : 16'h0;
  assign bus2.wdata   = sel ? wd : '0;

  assign resp  = sel ? bus2.resp : bus1.resp;
  assign rdata = sel ? bus2.rdata : bus1.rdata;

  line_mem_responder #(
    .LATENCY   (4),
    .NUM_LINES (2048)
  ) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1),
    .err   (err1)
  );

  line_mem_responder #(
    .LATENCY   (1),
    .NUM_LINES (256)
  ) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2),
    .err   (err2)
  );

  task automatic chk(input string tag,
                     input logic [255:0] got,
                     input logic [255:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one request; enters and leaves at a negedge.
  task automatic txn(input logic r,
                     input logic w,
                     input logic [15:0] a,
                     input logic [255:0] d,
                     input logic [255:0] exp,
                     input int lat,
                     input bit chg,
                     input logic [15:0] alt);
    int k;
    bit got;
    rd   = r;
    wr   = w;
    addr = a;
    wd   = d;
    @(posedge clk);
    k   = 0;
    got = 0;
    while (!got && k < 20) begin
      @(negedge clk);
      k++;
      if (resp) begin
        got = 1;
      end else begin
        chk("rdata_pre", rdata, '0);
        if (chg && k == 2) addr = alt;
      end
    end
    chk("latency", 256'(k), 256'(lat));
    chk("rdata_resp", rdata, exp);
    @(posedge clk);
    #1;
    rd   = 1'b0;
    wr   = 1'b0;
    addr = 16'h0;
    wd   = '0;
    @(negedge clk);
    chk("resp_one_cycle", 256'(resp), 256'(0));
    chk("rdata_post", rdata, '0);
  endtask

  logic [255:0] la5;
  logic [255:0] lrand;
  logic [255:0] p100;
  logic [255:0] p200;
  logic [255:0] pboth;
  logic [255:0] lalias;
  logic [255:0] pb2b [4];

  initial begin
    la5    = {32{8'hA5}};
    lrand  = {8{32'h1357_9BDF}};
    p100   = {16{16'h0100}};
    p200   = {16{16'h0200}};
    pboth  = {4{64'hC0FF_EE00_1234_5678}};
    lalias = {8{32'h2000_BEEF}};
    for (int i = 0; i < 4; i++) begin
      pb2b[i] = {8{32'hB0B0_0000 + 32'(i)}};
    end

    rst_n = 1'b0;
    sel   = 1'b0;
    rd    = 1'b0;
    wr    = 1'b0;
    addr  = 16'h0;
    wd    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_resp", 256'(resp), 256'(0));
    chk("rst_rdata", rdata, '0);
    chk("rst_err1", 256'(err1), 256'(0));
    chk("rst_err2", 256'(err2), 256'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // write then read
    txn(0, 1, 16'h0040, la5, '0, 4, 0, 16'h0);
    txn(1, 0, 16'h0040, '0, la5, 4, 0, 16'h0);

    // offset bits ignored
    txn(0, 1, 16'h1234, lrand, '0, 4, 0, 16'h0);
    txn(1, 0, 16'h1220, '0, lrand, 4, 0, 16'h0);

    // back-to-back writes then reads
    for (int i = 0; i < 4; i++) begin
      txn(0, 1, 16'h0400 + 16'(i * 32), pb2b[i], '0,
          4, 0, 16'h0);
    end
    for (int i = 0; i < 4; i++) begin
      txn(1, 0, 16'h0400 + 16'(i * 32), '0, pb2b[i],
          4, 0, 16'h0);
    end
    chk("b2b_err", 256'(err1), 256'(0));

    // address changed mid-WAIT
    txn(0, 1, 16'h0100, p100, '0, 4, 0, 16'h0);
    txn(0, 1, 16'h0200, p200, '0, 4, 0, 16'h0);
    chk("pre_viol_err", 256'(err1), 256'(0));
    txn(1, 0, 16'h0100, '0, p100, 4, 1, 16'h0200);
    chk("viol_err", 256'(err1), 256'(1));
    txn(1, 0, 16'h0200, '0, p200, 4, 0, 16'h0);
    chk("viol_sticky", 256'(err1), 256'(1));

    // reset during WAIT aborts the write
    txn(0, 1, 16'h0080, '0, '0, 4, 0, 16'h0);
    rd   = 1'b0;
    wr   = 1'b1;
    addr = 16'h0080;
    wd   = {256{1'b1}};
    @(posedge clk);
    @(negedge clk);
    chk("abort_wait", 256'(resp), 256'(0));
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_resp", 256'(resp), 256'(0));
      wr = 1'b0;
      wd = '0;
      addr = 16'h0;
    end
    chk("abort_err", 256'(err1), 256'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_idle", 256'(resp), 256'(0));
    txn(1, 0, 16'h0080, '0, '0, 4, 0, 16'h0);

    // read and write together: treated as write
    txn(1, 1, 16'h0300, pboth, '0, 4, 0, 16'h0);
    chk("both_err", 256'(err1), 256'(1));
    txn(1, 0, 16'h0300, '0, pboth, 4, 0, 16'h0);

    // LATENCY=1, 256-line build with aliasing
    sel = 1'b1;
    @(negedge clk);
    chk("l1_err0", 256'(err2), 256'(0));
    txn(0, 1, 16'h2000, lalias, '0, 1, 0, 16'h0);
    txn(1, 0, 16'h0000, '0, lalias, 1, 0, 16'h0);
    txn(1, 0, 16'h2000, '0, lalias, 1, 0, 16'h0);
    txn(0, 1, 16'h1234, la5, '0, 1, 0, 16'h0);
    txn(1, 0, 16'h1220, '0, la5, 1, 0, 16'h0);
    chk("l1_err", 256'(err2), 256'(0));

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
